// File: rtl/ili9341_pkg.sv
// Shared definitions for the ILI9341 init sequencer: ROM entry format,
// opcode constants, the fixed init ROM contents and hardware-reset timing.
package ili9341_pkg;

    // Kind of each ROM entry, stored in the top two bits of the entry.
    typedef enum logic [1:0] {
        ENT_CMD   = 2'd0,
        ENT_DATA  = 2'd1,
        ENT_DELAY = 2'd2,
        ENT_END   = 2'd3
    } entry_type_e;

    // One ROM word: {kind, value}. kind is kept as plain bits so that
    // kind[0] can drive the D/CX line directly.
    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] value;
    } rom_entry_t;

    localparam logic [7:0] OP_SWRESET = 8'h01;
    localparam logic [7:0] OP_SLPOUT  = 8'h11;
    localparam logic [7:0] OP_COLMOD  = 8'h3A;
    localparam logic [7:0] OP_RGBIF   = 8'hB0;
    localparam logic [7:0] OP_IFCTL   = 8'hF6;
    localparam logic [7:0] OP_DISPON  = 8'h29;

    localparam int ROM_DEPTH = 15;
    localparam int PTR_W     = $clog2(ROM_DEPTH);

    // Hardware reset: RESX low for 1 ms, then released for 5 ms before
    // the first command is sent.
    localparam int HWRST_LOW_MS  = 1;
    localparam int HWRST_WAIT_MS = 5;

    function automatic rom_entry_t mk_entry(input entry_type_e k, input logic [7:0] v);
        rom_entry_t e;
        e.kind  = k;
        e.value = v;
        return e;
    endfunction

    // Fixed init program: software reset, sleep out, 16-bit colour,
    // RGB interface setup, interface control, display on.
    function automatic rom_entry_t rom_entry(input int unsigned idx);
        rom_entry_t e;
        case (idx)
            0:       e = mk_entry(ENT_CMD,   OP_SWRESET);
            1:       e = mk_entry(ENT_DELAY, 8'd5);
            2:       e = mk_entry(ENT_CMD,   OP_SLPOUT);
            3:       e = mk_entry(ENT_DELAY, 8'd120);
            4:       e = mk_entry(ENT_CMD,   OP_COLMOD);
            5:       e = mk_entry(ENT_DATA,  8'h55);
            6:       e = mk_entry(ENT_CMD,   OP_RGBIF);
            7:       e = mk_entry(ENT_DATA,  8'h40);
            8:       e = mk_entry(ENT_CMD,   OP_IFCTL);
            9:       e = mk_entry(ENT_DATA,  8'h01);
            10:      e = mk_entry(ENT_DATA,  8'h00);
            11:      e = mk_entry(ENT_DATA,  8'h06);
            12:      e = mk_entry(ENT_CMD,   OP_DISPON);
            13:      e = mk_entry(ENT_DELAY, 8'd20);
            default: e = mk_entry(ENT_END,   8'h00);
        endcase
        return e;
    endfunction

endpackage

// File: rtl/ili9341_spi_byte_tx.sv
// Serial byte transmitter for the ILI9341 4-wire interface.
// On go it drops CSX, shifts one byte MSB first (SCL low then high for
// SPI_DIV cycles per half), raises CSX for an SPI_DIV-cycle gap and
// pulses done in the last gap cycle. All pin outputs are registered.
module ili9341_spi_byte_tx #(
    parameter int SPI_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic [7:0] tx_byte,
    input  logic       dc,
    output logic       done,
    output logic       gap,
    output logic       csx,
    output logic       dcx,
    output logic       scl,
    output logic       sda
);

    localparam int DIV_W = (SPI_DIV > 1) ? $clog2(SPI_DIV) : 1;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SHIFT,
        TX_GAP
    } tx_phase_e;

    tx_phase_e        phase_reg, phase_next;
    logic [DIV_W-1:0] div_reg, div_next;
    logic [2:0]       bit_reg, bit_next;
    logic [7:0]       shreg_reg, shreg_next;
    logic             csx_reg, csx_next;
    logic             dcx_reg, dcx_next;
    logic             scl_reg, scl_next;
    logic             sda_reg, sda_next;
    logic             div_last;

    assign div_last = (div_reg == DIV_W'(SPI_DIV - 1));
    assign done     = (phase_reg == TX_GAP) && div_last;
    assign gap      = (phase_reg == TX_GAP);
    assign csx      = csx_reg;
    assign dcx      = dcx_reg;
    assign scl      = scl_reg;
    assign sda      = sda_reg;

    // State and pin registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_reg <= TX_IDLE;
            div_reg   <= '0;
            bit_reg   <= '0;
            shreg_reg <= '0;
            csx_reg   <= 1'b1;
            dcx_reg   <= 1'b0;
            scl_reg   <= 1'b0;
            sda_reg   <= 1'b0;
        end else begin
            phase_reg <= phase_next;
            div_reg   <= div_next;
            bit_reg   <= bit_next;
            shreg_reg <= shreg_next;
            csx_reg   <= csx_next;
            dcx_reg   <= dcx_next;
            scl_reg   <= scl_next;
            sda_reg   <= sda_next;
        end
    end

    // Bit timing: SDA only moves on the edge where SCL returns low, so the
    // panel always sees stable data on the SCL rising edge.
    always_comb begin
        phase_next = phase_reg;
        div_next   = div_reg;
        bit_next   = bit_reg;
        shreg_next = shreg_reg;
        csx_next   = csx_reg;
        dcx_next   = dcx_reg;
        scl_next   = scl_reg;
        sda_next   = sda_reg;
        case (phase_reg)
            TX_IDLE: begin
                if (go) begin
                    phase_next = TX_SHIFT;
                    csx_next   = 1'b0;
                    dcx_next   = dc;
                    scl_next   = 1'b0;
                    sda_next   = tx_byte[7];
                    shreg_next = tx_byte;
                    bit_next   = 3'd7;
                    div_next   = '0;
                end
            end
            TX_SHIFT: begin
                if (div_last) begin
                    div_next = '0;
                    if (!scl_reg) begin
                        scl_next = 1'b1;
                    end else if (bit_reg == 3'd0) begin
                        phase_next = TX_GAP;
                        csx_next   = 1'b1;
                        scl_next   = 1'b0;
                    end else begin
                        bit_next   = bit_reg - 3'd1;
                        scl_next   = 1'b0;
                        shreg_next = {shreg_reg[6:0], 1'b0};
                        sda_next   = shreg_reg[6];
                    end
                end else begin
                    div_next = div_reg + DIV_W'(1);
                end
            end
            TX_GAP: begin
                if (div_last) begin
                    phase_next = TX_IDLE;
                    div_next   = '0;
                end else begin
                    div_next = div_reg + DIV_W'(1);
                end
            end
            default: phase_next = TX_IDLE;
        endcase
    end

endmodule

// File: rtl/ili9341_init_sequencer.sv
// ILI9341 power-up sequencer: walks the fixed init ROM (commands,
// parameters, millisecond delays, end marker), sends bytes through the
// serial transmitter and raises panel_ready when the program completes.
// Optional: define ILI9341_HW_RESET_EN to generate the RESX pulse before
// the first command; otherwise lcd_resx is tied high.
module ili9341_init_sequencer
    import ili9341_pkg::*;
#(
    parameter int CLKS_PER_MS = 1000,
    parameter int SPI_DIV     = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic panel_ready,
    output logic lcd_resx,
    output logic lcd_csx,
    output logic lcd_dcx,
    output logic lcd_scl,
    output logic lcd_sda
);

    localparam int DLY_W = $clog2(255 * CLKS_PER_MS + 1);

`ifdef ILI9341_HW_RESET_EN
    localparam int HWRST_LOW_CYC  = HWRST_LOW_MS * CLKS_PER_MS;
    localparam int HWRST_WAIT_CYC = HWRST_WAIT_MS * CLKS_PER_MS;

    typedef enum logic [2:0] {
        ST_IDLE, ST_HWRST_LOW, ST_HWRST_WAIT, ST_FETCH,
        ST_SHIFT, ST_GAP, ST_DELAY, ST_DONE
    } state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_SHIFT, ST_GAP, ST_DELAY, ST_DONE
    } state_e;
`endif

    state_e           state_reg, state_next;
    logic [PTR_W-1:0] ptr_reg, ptr_next, ptr_inc;
    logic [DLY_W-1:0] cnt_reg, cnt_next;
    logic             busy_reg, busy_next;
    logic             ready_reg, ready_next;
    logic             go_reg, go_next;
    logic [DLY_W-1:0] delay_total;
    logic             tx_done;
    logic             tx_gap;
    rom_entry_t       fetched;
    rom_entry_t       rom [ROM_DEPTH];

    // Init program as a constant table, one word per entry.
    genvar gi;
    for (gi = 0; gi < ROM_DEPTH; gi++) begin : g_rom
        assign rom[gi] = rom_entry(gi);
    end

    assign fetched     = rom[ptr_reg];
    assign delay_total = DLY_W'(fetched.value) * DLY_W'(CLKS_PER_MS);
    // The pointer never moves past the END word.
    assign ptr_inc     = (ptr_reg == PTR_W'(ROM_DEPTH - 1)) ? ptr_reg : ptr_reg + PTR_W'(1);

    assign busy        = busy_reg;
    assign panel_ready = ready_reg;

    // Sequencer state and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            ready_reg <= 1'b0;
            go_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
            busy_reg  <= busy_next;
            ready_reg <= ready_next;
            go_reg    <= go_next;
        end
    end

    // Next-state logic. A DELAY entry of N ms spends N*CLKS_PER_MS cycles
    // from its fetch to the next fetch (fetch cycle included); N=0 costs
    // only the fetch itself. Down-counters expire at zero.
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        busy_next  = busy_reg;
        ready_next = ready_reg;
        go_next    = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    busy_next  = 1'b1;
                    ready_next = 1'b0;
                    ptr_next   = '0;
`ifdef ILI9341_HW_RESET_EN
                    state_next = ST_HWRST_LOW;
                    cnt_next   = DLY_W'(HWRST_LOW_CYC - 1);
`else
                    state_next = ST_FETCH;
`endif
                end
            end
`ifdef ILI9341_HW_RESET_EN
            ST_HWRST_LOW: begin
                if (cnt_reg == '0) begin
                    state_next = ST_HWRST_WAIT;
                    cnt_next   = DLY_W'(HWRST_WAIT_CYC - 1);
                end else begin
                    cnt_next = cnt_reg - DLY_W'(1);
                end
            end
            ST_HWRST_WAIT: begin
                if (cnt_reg == '0) begin
                    state_next = ST_FETCH;
                end else begin
                    cnt_next = cnt_reg - DLY_W'(1);
                end
            end
`endif
            ST_FETCH: begin
                case (fetched.kind)
                    ENT_CMD, ENT_DATA: begin
                        state_next = ST_SHIFT;
                        go_next    = 1'b1;
                    end
                    ENT_DELAY: begin
                        if (delay_total <= DLY_W'(1)) begin
                            ptr_next = ptr_inc;
                        end else begin
                            state_next = ST_DELAY;
                            cnt_next   = delay_total - DLY_W'(2);
                        end
                    end
                    default: begin
                        state_next = ST_DONE;
                        busy_next  = 1'b0;
                        ready_next = 1'b1;
                    end
                endcase
            end
            ST_SHIFT: begin
                if (tx_done) begin
                    state_next = ST_FETCH;
                    ptr_next   = ptr_inc;
                end else if (tx_gap) begin
                    state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (tx_done) begin
                    state_next = ST_FETCH;
                    ptr_next   = ptr_inc;
                end
            end
            ST_DELAY: begin
                if (cnt_reg == '0) begin
                    state_next = ST_FETCH;
                    ptr_next   = ptr_inc;
                end else begin
                    cnt_next = cnt_reg - DLY_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

`ifdef ILI9341_HW_RESET_EN
    logic resx_reg;

    // RESX follows the low-pulse state one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            resx_reg <= 1'b1;
        end else begin
            resx_reg <= (state_reg != ST_HWRST_LOW);
        end
    end

    assign lcd_resx = resx_reg;
`else
    assign lcd_resx = 1'b1;
`endif

    ili9341_spi_byte_tx #(
        .SPI_DIV (SPI_DIV)
    ) u_spi_tx (
        .clk     (clk),
        .reset   (reset),
        .go      (go_reg),
        .tx_byte (fetched.value),
        .dc      (fetched.kind[0]),
        .done    (tx_done),
        .gap     (tx_gap),
        .csx     (lcd_csx),
        .dcx     (lcd_dcx),
        .scl     (lcd_scl),
        .sda     (lcd_sda)
    );

endmodule

// File: tb/tb_ili9341_init_sequencer.sv
// Testbench for ili9341_init_sequencer (CLKS_PER_MS=10, SPI_DIV=2).
// A negedge monitor captures bytes off the serial pins; each scenario task
// compares the captured stream and its timing with a table-driven model.
module tb_ili9341_init_sequencer;

    localparam int CLKS_PER_MS = 10;
    localparam int SPI_DIV     = 2;
    localparam int NBYTES      = 11;
    localparam int BYTE_CYC    = 16 * SPI_DIV;
    localparam int WAIT_LIMIT  = 5000;
`ifdef ILI9341_HW_RESET_EN
    localparam bit HW_RST      = 1'b1;
    localparam int FIRST_FALL  = 6 * CLKS_PER_MS + 2;
`else
    localparam bit HW_RST      = 1'b0;
    localparam int FIRST_FALL  = 2;
`endif

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic busy, panel_ready, lcd_resx, lcd_csx, lcd_dcx, lcd_scl, lcd_sda;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    typedef struct {
        logic [7:0] data;
        logic       dc;
        logic       dc_stable;
        int         bits;
        int         fall;
        int         rise;
    } rec_t;

    rec_t       got [$];
    rec_t       mon_rec;
    logic       mon_active = 1'b0;
    logic [7:0] mon_sh     = '0;
    int         mon_bits   = 0;
    logic       mon_dc     = 1'b0;
    logic       mon_stable = 1'b1;
    int         mon_fall   = 0;
    logic       prev_scl   = 1'b0;

    // Reference model: the byte stream and the ms delay preceding each byte.
    logic [7:0] exp_byte [NBYTES];
    logic       exp_dc   [NBYTES];
    int         exp_ms   [NBYTES];
    localparam int FINAL_MS = 20;

    ili9341_init_sequencer #(
        .CLKS_PER_MS (CLKS_PER_MS),
        .SPI_DIV     (SPI_DIV)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .busy        (busy),
        .panel_ready (panel_ready),
        .lcd_resx    (lcd_resx),
        .lcd_csx     (lcd_csx),
        .lcd_dcx     (lcd_dcx),
        .lcd_scl     (lcd_scl),
        .lcd_sda     (lcd_sda)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Panel-side monitor: SDA sampled on each SCL rise inside a CSX-low window.
    always @(negedge clk) begin
        if (reset) begin
            mon_active = 1'b0;
            prev_scl   = 1'b0;
        end else begin
            if (!mon_active && lcd_csx === 1'b0) begin
                mon_active = 1'b1;
                mon_sh     = '0;
                mon_bits   = 0;
                mon_dc     = lcd_dcx;
                mon_stable = 1'b1;
                mon_fall   = cyc;
            end
            if (mon_active) begin
                if (lcd_csx === 1'b1) begin
                    mon_rec.data      = mon_sh;
                    mon_rec.dc        = mon_dc;
                    mon_rec.dc_stable = mon_stable;
                    mon_rec.bits      = mon_bits;
                    mon_rec.fall      = mon_fall;
                    mon_rec.rise      = cyc;
                    got.push_back(mon_rec);
                    mon_active = 1'b0;
                end else begin
                    if (lcd_dcx !== mon_dc) mon_stable = 1'b0;
                    if (!prev_scl && lcd_scl === 1'b1) begin
                        mon_sh   = {mon_sh[6:0], lcd_sda};
                        mon_bits = mon_bits + 1;
                    end
                end
            end
            prev_scl = lcd_scl;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] obs;
        logic [6:0] want;
        string      nm [7];
        nm = '{"busy", "panel_ready", "resx", "csx", "dcx", "scl", "sda"};
        reset = 1'b1;
        start = 1'b0;
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        want = 7'b0011000;
        obs  = {busy, panel_ready, lcd_resx, lcd_csx, lcd_dcx, lcd_scl, lcd_sda};
        for (int i = 0; i < 7; i++) begin
            tests_run++;
            if (obs[6-i] !== want[6-i]) begin
                tests_failed++;
                $display("FAIL reset_%s: got %b want %b", nm[i], obs[6-i], want[6-i]);
            end
        end
        reset = 1'b0;
        repeat (4) tick();
        tests_run++;
        if ({busy, lcd_csx} !== 2'b01) begin
            tests_failed++;
            $display("FAIL idle_after_reset: busy/csx got %b want 01", {busy, lcd_csx});
        end
        $display("[TB] reset: outputs checked");
    endtask

    task automatic test_full_sequence();
        int   k;
        int   ready_cyc;
        int   exp_fall;
        int   n;
        logic early_drop;
        got.delete();
        repeat ($urandom_range(0, 7)) tick();
        start = 1'b1;
        k = cyc + 1;
        tick();
        start = 1'b0;
        tests_run++;
        if ({busy, panel_ready} !== 2'b10) begin
            tests_failed++;
            $display("FAIL start_status: busy/ready got %b want 10", {busy, panel_ready});
        end
        for (int c = 0; c <= 12; c++) begin
            tests_run++;
            if (lcd_resx !== !(HW_RST && c >= 1 && c <= 10)) begin
                tests_failed++;
                $display("FAIL resx_k+%0d: got %b want %b", c, lcd_resx, !(HW_RST && c >= 1 && c <= 10));
            end
            tick();
        end
        ready_cyc  = -1;
        early_drop = 1'b0;
        for (int i = 0; i < WAIT_LIMIT && ready_cyc < 0; i++) begin
            if (panel_ready === 1'b1) ready_cyc = cyc;
            else begin
                if (busy !== 1'b1) early_drop = 1'b1;
                tick();
            end
        end
        tests_run++;
        if (ready_cyc < 0 || early_drop) begin
            tests_failed++;
            $display("FAIL ready_wait: ready_cyc %0d early_busy_drop %b want ready and no drop", ready_cyc, early_drop);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_at_ready: got %b want 0", busy);
        end
        tests_run++;
        if (got.size() != NBYTES) begin
            tests_failed++;
            $display("FAIL byte_count: got %0d want %0d", got.size(), NBYTES);
        end
        n = (got.size() < NBYTES) ? got.size() : NBYTES;
        exp_fall = k + FIRST_FALL;
        for (int i = 0; i < n; i++) begin
            if (i > 0) exp_fall = exp_fall + BYTE_CYC + SPI_DIV + 2 + exp_ms[i] * CLKS_PER_MS;
            tests_run++;
            if ({got[i].dc, got[i].data} !== {exp_dc[i], exp_byte[i]} || !got[i].dc_stable || got[i].bits != 8) begin
                tests_failed++;
                $display("FAIL byte%0d_value: got dc=%b %h bits=%0d stable=%b want dc=%b %h bits=8",
                         i, got[i].dc, got[i].data, got[i].bits, got[i].dc_stable, exp_dc[i], exp_byte[i]);
            end
            tests_run++;
            if (got[i].fall != exp_fall || got[i].rise - got[i].fall != BYTE_CYC) begin
                tests_failed++;
                $display("FAIL byte%0d_timing: csx fall %0d width %0d want fall %0d width %0d",
                         i, got[i].fall - k, got[i].rise - got[i].fall, exp_fall - k, BYTE_CYC);
            end
            $display("[TB] byte %0d: %h dc=%b fall=k+%0d", i, got[i].data, got[i].dc, got[i].fall - k);
        end
        if (n == NBYTES) begin
            tests_run++;
            if (ready_cyc != got[NBYTES-1].rise + SPI_DIV + FINAL_MS * CLKS_PER_MS + 1) begin
                tests_failed++;
                $display("FAIL ready_time: got %0d want %0d after last csx rise",
                         ready_cyc - got[NBYTES-1].rise, SPI_DIV + FINAL_MS * CLKS_PER_MS + 1);
            end
        end
    endtask

    task automatic test_start_mid_sequence();
        int   k;
        int   ready_cyc;
        logic found;
        got.delete();
        start = 1'b1;
        k = cyc + 1;
        tick();
        start = 1'b0;
        tests_run++;
        if ({busy, panel_ready} !== 2'b10) begin
            tests_failed++;
            $display("FAIL restart_from_done: busy/ready got %b want 10", {busy, panel_ready});
        end
        found = 1'b0;
        for (int i = 0; i < WAIT_LIMIT && !found; i++) begin
            if (got.size() == 2 && lcd_csx === 1'b0) found = 1'b1;
            else tick();
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL wait_3a_window: got timeout want csx low on third byte");
        end
        repeat ($urandom_range(0, 28)) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < WAIT_LIMIT && !found; i++) begin
            if (got.size() == NBYTES) found = 1'b1;
            else tick();
        end
        repeat ($urandom_range(5, 150)) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        ready_cyc = -1;
        for (int i = 0; i < WAIT_LIMIT && ready_cyc < 0; i++) begin
            if (panel_ready === 1'b1) ready_cyc = cyc;
            else tick();
        end
        tests_run++;
        if (got.size() != NBYTES || ready_cyc < 0) begin
            tests_failed++;
            $display("FAIL mid_start_count: bytes %0d ready_cyc %0d want %0d bytes and ready", got.size(), ready_cyc, NBYTES);
        end
        for (int i = 0; i < got.size() && i < NBYTES; i++) begin
            tests_run++;
            if ({got[i].dc, got[i].data} !== {exp_dc[i], exp_byte[i]}) begin
                tests_failed++;
                $display("FAIL mid_start_byte%0d: got dc=%b %h want dc=%b %h", i, got[i].dc, got[i].data, exp_dc[i], exp_byte[i]);
            end
        end
        if (got.size() == NBYTES && ready_cyc >= 0) begin
            tests_run++;
            if (got[0].fall != k + FIRST_FALL ||
                ready_cyc != got[NBYTES-1].rise + SPI_DIV + FINAL_MS * CLKS_PER_MS + 1) begin
                tests_failed++;
                $display("FAIL mid_start_timing: first fall k+%0d ready rise+%0d want k+%0d rise+%0d",
                         got[0].fall - k, ready_cyc - got[NBYTES-1].rise, FIRST_FALL, SPI_DIV + FINAL_MS * CLKS_PER_MS + 1);
            end
        end
        $display("[TB] start mid-sequence: %0d bytes captured", got.size());
    endtask

    task automatic test_reset_mid_byte();
        int   ready_cyc;
        logic found;
        got.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < WAIT_LIMIT && !found; i++) begin
            if (got.size() == 4 && lcd_csx === 1'b0 && mon_bits == 3 && lcd_scl === 1'b0) found = 1'b1;
            else tick();
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL wait_b0_bit4: got timeout want bit 4 of B0");
        end
        reset = 1'b1;
        tick();
        tests_run++;
        if ({lcd_csx, lcd_scl, busy, panel_ready, lcd_resx} !== 5'b10001) begin
            tests_failed++;
            $display("FAIL reset_mid_byte: csx/scl/busy/ready/resx got %b want 10001",
                     {lcd_csx, lcd_scl, busy, panel_ready, lcd_resx});
        end
        tick();
        reset = 1'b0;
        repeat ($urandom_range(1, 6)) tick();
        got.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        ready_cyc = -1;
        for (int i = 0; i < WAIT_LIMIT && ready_cyc < 0; i++) begin
            if (panel_ready === 1'b1) ready_cyc = cyc;
            else tick();
        end
        tests_run++;
        if (got.size() != NBYTES || ready_cyc < 0) begin
            tests_failed++;
            $display("FAIL rerun_count: bytes %0d ready_cyc %0d want %0d bytes and ready", got.size(), ready_cyc, NBYTES);
        end
        for (int i = 0; i < got.size() && i < NBYTES; i++) begin
            tests_run++;
            if ({got[i].dc, got[i].data} !== {exp_dc[i], exp_byte[i]} || got[i].bits != 8) begin
                tests_failed++;
                $display("FAIL rerun_byte%0d: got dc=%b %h bits=%0d want dc=%b %h bits=8",
                         i, got[i].dc, got[i].data, got[i].bits, exp_dc[i], exp_byte[i]);
            end
        end
        $display("[TB] reset mid-byte: rerun captured %0d bytes", got.size());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        exp_byte = '{8'h01, 8'h11, 8'h3A, 8'h55, 8'hB0, 8'h40, 8'hF6, 8'h01, 8'h00, 8'h06, 8'h29};
        exp_dc   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_ms   = '{0, 5, 120, 0, 0, 0, 0, 0, 0, 0, 0};
        test_reset();
        test_full_sequence();
        test_start_mid_sequence();
        test_reset_mid_byte();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
